multi_cycle_cla_adder: RTL and testbench

//   Sequencer that sits directly upstream and downstream of one Carry_Lookahead_Adder instance.

---
 rtl/multi_cycle_cla_adder_pkg.sv | 33 +++
 rtl/multi_cycle_cla_adder_cla.sv | 67 ++++++
 rtl/multi_cycle_cla_adder.sv | 106 ++++++++++
 tb/tb_multi_cycle_cla_adder.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_cycle_cla_adder_pkg.sv
// Shared types and elaboration-time helpers for the multi-cycle CLA adder.
// The helpers size the chunk sequencer and the lookahead tree.
package adder_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} mca_state_t;

    function automatic int nchunk(input int total, input int chunk);
        return total / chunk;
    endfunction

    // Number of base-sized levels needed to reduce value to one group.
    function automatic int log_base(input int value, input int base);
        int v;
        int n;
        v = value;
        n = 0;
        if (base < 2) return 0;
        while (v > 1) begin
            v = v / base;
            n++;
        end
        return n;
    endfunction

    function automatic bit is_power_of(input int value, input int base);
        int v;
        v = value;
        if (base < 2 || v < base) return 1'b0;
        while (v > 1 && (v % base) == 0) v = v / base;
        return (v == 1);
    endfunction

endpackage

// File: rtl/multi_cycle_cla_adder_cla.sv
// Combinational carry-lookahead adder built as a SIZE-ary tree of group generate/propagate
// terms; carries flow back down the tree so every bit's carry is a closed-form lookahead.
module Carry_Lookahead_Adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SIZE  = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    localparam int LEVELS = log_base(WIDTH, SIZE);

    // Carry out of the first n positions of one SIZE-wide group, given its carry in.
    function automatic logic lookahead(input logic [SIZE-1:0] g, input logic [SIZE-1:0] p,
                                       input logic ci, input int n);
        logic c;
        logic [SIZE-1:0] gs;
        logic [SIZE-1:0] ps;
        c  = ci;
        gs = g;
        ps = p;
        for (int i = 0; i < SIZE; i++) begin
            if (i < n) c = gs[0] | (ps[0] & c);
            gs = gs >> 1;
            ps = ps >> 1;
        end
        return c;
    endfunction

    for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
        localparam int N = WIDTH / (SIZE ** l);
        logic [N-1:0] gv;
        logic [N-1:0] pv;
        logic [N-1:0] cv;

        if (l == 0) begin : g_leaf
            assign gv = a & b;
            assign pv = a ^ b;
        end else begin : g_node
            for (genvar j = 0; j < N; j++) begin : g_grp
                assign gv[j] = lookahead(g_lvl[l-1].gv[j*SIZE +: SIZE],
                                         g_lvl[l-1].pv[j*SIZE +: SIZE], 1'b0, SIZE);
                assign pv[j] = &g_lvl[l-1].pv[j*SIZE +: SIZE];
            end
        end

        if (l == LEVELS) begin : g_root
            assign cv = cin;
        end else begin : g_down
            for (genvar j = 0; j < N / SIZE; j++) begin : g_par
                for (genvar m = 0; m < SIZE; m++) begin : g_pos
                    assign cv[j*SIZE + m] = lookahead(gv[j*SIZE +: SIZE], pv[j*SIZE +: SIZE],
                                                      g_lvl[l+1].cv[j], m);
                end
            end
        end
    end

    assign s    = g_lvl[0].pv ^ g_lvl[0].cv;
    assign cout = g_lvl[LEVELS].gv[0] | (g_lvl[LEVELS].pv[0] & cin);

endmodule

// File: rtl/multi_cycle_cla_adder.sv
// Wide adder that streams operands through one CHUNK_WIDTH CLA, LSB slice first,
// carrying the slice carry-out into the next cycle. Valid/ready on both sides.
module multi_cycle_cla_adder
    import adder_pkg::*;
#(
    parameter int TOTAL_WIDTH = 64,
    parameter int CHUNK_WIDTH = 16,
    parameter int CLA_SIZE    = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [TOTAL_WIDTH-1:0] a,
    input  logic [TOTAL_WIDTH-1:0] b,
    input  logic                   cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [TOTAL_WIDTH-1:0] sum,
    output logic                   cout
);

    localparam int NCHUNK = nchunk(TOTAL_WIDTH, CHUNK_WIDTH);
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int BASE_W = (TOTAL_WIDTH > 1) ? $clog2(TOTAL_WIDTH) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    if (TOTAL_WIDTH % CHUNK_WIDTH != 0) begin : g_bad_total
        $error("TOTAL_WIDTH must be a multiple of CHUNK_WIDTH");
    end
    if (!is_power_of(CHUNK_WIDTH, CLA_SIZE)) begin : g_bad_chunk
        $error("CHUNK_WIDTH must be a power of CLA_SIZE");
    end

    mca_state_t             state;
    logic [IDX_W-1:0]       idx;
    logic                   carry;
    logic [TOTAL_WIDTH-1:0] a_sr;
    logic [TOTAL_WIDTH-1:0] b_sr;
    logic [CHUNK_WIDTH-1:0] cla_s;
    logic                   cla_cout;
    logic [BASE_W-1:0]      slice_base;
    logic                   accept;

    Carry_Lookahead_Adder #(.WIDTH(CHUNK_WIDTH), .SIZE(CLA_SIZE)) u_cla (
        .a    (a_sr[CHUNK_WIDTH-1:0]),
        .b    (b_sr[CHUNK_WIDTH-1:0]),
        .cin  (carry),
        .s    (cla_s),
        .cout (cla_cout)
    );

    // DONE hands in_ready to the consumer so a new add can start on the retire cycle.
    always_comb begin
        in_ready = 1'b0;
        case (state)
            IDLE:    in_ready = 1'b1;
            DONE:    in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    assign out_valid  = (state == DONE);
    assign accept     = in_valid & in_ready;
    assign slice_base = BASE_W'(int'(idx) * CHUNK_WIDTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            a_sr  <= '0;
            b_sr  <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else if (accept) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            idx   <= '0;
            state <= BUSY;
        end else begin
            case (state)
                BUSY: begin
                    sum[slice_base +: CHUNK_WIDTH] <= cla_s;
                    carry <= cla_cout;
                    a_sr  <= a_sr >> CHUNK_WIDTH;
                    b_sr  <= b_sr >> CHUNK_WIDTH;
                    if (idx == LAST_IDX) begin
                        cout  <= cla_cout;
                        idx   <= '0;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                IDLE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi_cycle_cla_adder.sv
// Scoreboard bench: a 64/16/4 adder and a single-chunk 16/16/4 adder driven with directed
// and random operands, checked against plain a+b+cin arithmetic.
module tb_multi_cycle_cla_adder;

    localparam int TW  = 64;
    localparam int CW  = 16;
    localparam int NCH = TW / CW;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
    } result_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, cin, out_valid, cout;
    logic [TW-1:0] a, b, sum;
    logic          in_valid_n, in_ready_n, cin_n, out_valid_n, cout_n;
    logic [15:0]   a_n, b_n, sum_n;
    logic          out_ready, or_fixed, bp_en, bp_rnd;

    assign out_ready = bp_en ? bp_rnd : or_fixed;

    multi_cycle_cla_adder #(.TOTAL_WIDTH(TW), .CHUNK_WIDTH(CW), .CLA_SIZE(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum), .cout(cout)
    );

    multi_cycle_cla_adder #(.TOTAL_WIDTH(16), .CHUNK_WIDTH(16), .CLA_SIZE(4)) dut_n (
        .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n), .a(a_n), .b(b_n),
        .cin(cin_n), .out_valid(out_valid_n), .out_ready(out_ready), .sum(sum_n), .cout(cout_n)
    );

    result_t exp_q[$];
    result_t exp_n_q[$];
    result_t mon_r, mon_n_r;
    int errors = 0;
    int checks = 0;
    int cyc = 0;

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1 bp_rnd = ($urandom_range(0, 3) != 0);
    end

    function automatic result_t model(input logic [63:0] x, input logic [63:0] y,
                                      input logic c, input int width);
        logic [64:0] full;
        logic [64:0] mask;
        result_t r;
        full   = {1'b0, x} + {1'b0, y} + 65'(c);
        mask   = (65'd1 << width) - 65'd1;
        r.sum  = 64'(full & mask);
        r.cout = full[width];
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result64", 64'd1, 64'd0);
            end else begin
                mon_r = exp_q.pop_front();
                check("sum64", sum, mon_r.sum);
                check("cout64", 64'(cout), 64'(mon_r.cout));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && out_valid_n && out_ready) begin
            if (exp_n_q.size() == 0) begin
                check("unexpected_result16", 64'd1, 64'd0);
            end else begin
                mon_n_r = exp_n_q.pop_front();
                check("sum16", 64'(sum_n), mon_n_r.sum);
                check("cout16", 64'(cout_n), 64'(mon_n_r.cout));
            end
        end
    end

    task automatic apply_stimulus(input logic [63:0] x, input logic [63:0] y, input logic c,
                                  output int acc);
        int n;
        in_valid = 1'b1;
        a = x;
        b = y;
        cin = c;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (!in_ready) begin
            check("accept_timeout64", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            exp_q.push_back(model(x, y, c, TW));
        end
        in_valid = 1'b0;
    endtask

    task automatic apply_stimulus_n(input logic [15:0] x, input logic [15:0] y, input logic c,
                                    output int acc);
        int n;
        in_valid_n = 1'b1;
        a_n = x;
        b_n = y;
        cin_n = c;
        n = 0;
        @(negedge clk);
        while (!in_ready_n && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = -1;
        if (!in_ready_n) begin
            check("accept_timeout16", 64'd0, 64'd1);
        end else begin
            @(posedge clk);
            #1;
            acc = cyc;
            exp_n_q.push_back(model(64'(x), 64'(y), c, 16));
        end
        in_valid_n = 1'b0;
    endtask

    task automatic wait_valid(input bit narrow, output int when);
        int n;
        n = 0;
        @(negedge clk);
        while (!(narrow ? out_valid_n : out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        when = cyc;
        if (!(narrow ? out_valid_n : out_valid)) check("valid_timeout", 64'd0, 64'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || exp_n_q.size() != 0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending", 64'(exp_q.size() + exp_n_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        case ($urandom_range(0, 7))
            0:       return '1;
            1:       return 64'd0;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int acc, acc2, when;
        result_t r;
        logic [63:0] x, y;
        logic c;

        rst = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        in_valid_n = 1'b0; a_n = '0; b_n = '0; cin_n = 1'b0;
        or_fixed = 1'b1; bp_en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_sum", sum, 64'd0);
        check("reset_cout", 64'(cout), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Full carry ripple across every slice, with latency measurement.
        apply_stimulus(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, acc);
        wait_valid(1'b0, when);
        check("t1_latency", 64'(when - acc), 64'(NCH));
        check("t1_sum", sum, 64'd0);
        check("t1_cout", 64'(cout), 64'd1);
        drain();

        apply_stimulus(64'h0000_0000_0000_FFFF, 64'd0, 1'b1, acc);
        wait_valid(1'b0, when);
        check("t2_sum", sum, 64'h0000_0000_0001_0000);
        drain();

        // Consumer stall: result must hold steady while out_ready is low.
        or_fixed = 1'b0;
        x = rnd64(); y = rnd64(); c = 1'($urandom);
        r = model(x, y, c, TW);
        apply_stimulus(x, y, c, acc);
        wait_valid(1'b0, when);
        for (int i = 0; i < 3; i++) begin
            check("t3_hold_valid", 64'(out_valid), 64'd1);
            check("t3_hold_in_ready", 64'(in_ready), 64'd0);
            check("t3_hold_sum", sum, r.sum);
            check("t3_hold_cout", 64'(cout), 64'(r.cout));
            @(negedge clk);
        end
        @(posedge clk);
        #1 or_fixed = 1'b1;
        drain();

        // Back-to-back: second accept lands on the DONE cycle of the first.
        apply_stimulus(64'd1, 64'd2, 1'b0, acc);
        apply_stimulus(64'd3, 64'd4, 1'b0, acc2);
        check("t4_issue_spacing", 64'(acc2 - acc), 64'(NCH + 1));
        wait_valid(1'b0, when);
        check("t4_second_sum", sum, 64'd7);
        drain();

        // Reset while BUSY at idx 2 discards the add.
        apply_stimulus(rnd64(), rnd64(), 1'b1, acc);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        #1;
        check("t5_rst_out_valid", 64'(out_valid), 64'd0);
        check("t5_rst_sum", sum, 64'd0);
        check("t5_rst_cout", 64'(cout), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("t5_in_ready", 64'(in_ready), 64'd1);
        check("t5_out_valid", 64'(out_valid), 64'd0);
        @(posedge clk);
        #1;
        apply_stimulus(64'd5, 64'd6, 1'b0, acc);
        wait_valid(1'b0, when);
        check("t5_sum", sum, 64'd11);
        drain();

        // Single-chunk configuration.
        apply_stimulus_n(16'h8000, 16'h8000, 1'b0, acc);
        wait_valid(1'b1, when);
        check("t6_latency", 64'(when - acc), 64'd1);
        check("t6_sum", 64'(sum_n), 64'd0);
        check("t6_cout", 64'(cout_n), 64'd1);
        drain();

        // Random traffic on both instances under random backpressure.
        bp_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 1500; i++) begin
                    apply_stimulus(rnd64(), rnd64(), 1'($urandom), acc);
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                    end
                end
            end
            begin
                for (int i = 0; i < 1500; i++) begin
                    apply_stimulus_n(16'(rnd64()), 16'(rnd64()), 1'($urandom), acc2);
                end
            end
        join
        bp_en = 1'b0;
        drain();

        check("leftover64", 64'(exp_q.size()), 64'd0);
        check("leftover16", 64'(exp_n_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
